// File: rtl/music_pkg.sv
// Shared types and helpers for the music sequencer control path.
package music_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED,
    ST_FETCH,
    ST_PLAY,
    ST_SONG_END
  } state_t;

  // Note code that means silence, and the duration that ends a song.
  localparam int NOTE_REST = 0;
  localparam int DUR_END   = 0;

  // A ROM entry is {note, duration}; duration sits in the low dur_w bits.
  function automatic logic [63:0] field_note(input logic [63:0] entry, input int dur_w);
    return entry >> dur_w;
  endfunction

  function automatic logic [63:0] field_dur(input logic [63:0] entry, input int dur_w);
    return entry & ((64'd1 << dur_w) - 64'd1);
  endfunction

  // Simulation builds use a short beat so songs finish in a few thousand cycles.
  function automatic int eff_div(input int sim, input int beat_div);
    return (sim != 0) ? 64 : beat_div;
  endfunction

endpackage

// File: rtl/beat_gen.sv
// Frame-strobe synchroniser and free-running beat divider.
module beat_gen #(
  parameter int DIV = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic new_frame,
  output logic sample_tick,
  output logic beat
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic             q1;
  logic             q2;
  logic [CNT_W-1:0] cnt;

  assign sample_tick = q1 & ~q2;
  assign beat        = sample_tick & (cnt == CNT_LAST);

  // Bring the codec frame strobe into the clock domain; q2 delays for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= new_frame;
      q2 <= q1;
    end
  end

  // Count sample ticks; transport events never touch this counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (sample_tick) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: transport control, ROM note fetch and tone-generator drive.
module music_sequencer
  import music_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int PTR_W     = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int BEAT_DIV  = 1000,
  parameter int SIM       = 0,
  localparam int SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_pause,
  input  logic                      next,
  input  logic                      prev,
  input  logic                      loop,
  input  logic                      new_frame,
  output logic                      rom_req,
  output logic [SONG_W+PTR_W-1:0]   rom_addr,
  input  logic                      rom_valid,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic                      play,
  output logic [SONG_W-1:0]         song,
  output logic [NOTE_W-1:0]         note,
  output logic                      note_valid,
  output logic                      new_note,
  output logic                      sample_tick,
  output logic                      beat,
  output logic                      song_done
);

  localparam int                DIV       = eff_div(SIM, BEAT_DIV);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = {PTR_W{1'b1}};

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [DUR_W-1:0]   remaining;
  logic               last;
  logic               pending;
  logic               stale;
  logic               issued;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;
  logic               req_ok;
  logic               rsp_ok;

  // Song index wraps over a count that need not be a power of two.
  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
    return (s == SONG_LAST) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
    return (s == '0) ? SONG_LAST : s - 1'b1;
  endfunction

  beat_gen #(
    .DIV(DIV)
  ) u_beat_gen (
    .clk        (clk),
    .reset      (reset),
    .new_frame  (new_frame),
    .sample_tick(sample_tick),
    .beat       (beat)
  );

  assign rom_note  = NOTE_W'(field_note(64'(rom_data), DUR_W));
  assign rom_dur   = DUR_W'(field_dur(64'(rom_data), DUR_W));
  assign rom_addr  = {song, ptr};
  assign play      = (state != ST_PAUSED);
  assign song_done = (state == ST_SONG_END);

  // A new request may go out once nothing is in flight, or the stale reply lands now.
  assign req_ok = ~pending | (rom_valid & stale);
  // Only the reply to the live request is ever loaded.
  assign rsp_ok = rom_valid & pending & ~stale;

  // Transport FSM; next/prev override everything, then per-state behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PAUSED;
      song       <= '0;
      ptr        <= '0;
      remaining  <= '0;
      last       <= 1'b0;
      pending    <= 1'b0;
      stale      <= 1'b0;
      issued     <= 1'b0;
      note       <= '0;
      note_valid <= 1'b0;
      new_note   <= 1'b0;
      rom_req    <= 1'b0;
    end else begin
      rom_req  <= 1'b0;
      new_note <= 1'b0;
      if (rom_valid && pending) begin
        pending <= 1'b0;
        stale   <= 1'b0;
      end
      if (next || prev) begin
        song       <= next ? song_inc(song) : song_dec(song);
        ptr        <= '0;
        remaining  <= '0;
        last       <= 1'b0;
        note       <= NOTE_W'(NOTE_REST);
        note_valid <= 1'b0;
        state      <= ST_PAUSED;
        if (pending && !rom_valid) stale <= 1'b1;
      end else begin
        case (state)
          ST_PAUSED: begin
            if (play_pause) begin
              if (remaining != '0) begin
                state <= ST_PLAY;
              end else begin
                state  <= ST_FETCH;
                issued <= 1'b0;
              end
            end
          end
          ST_FETCH: begin
            if (play_pause) begin
              state <= ST_PAUSED;
              if (pending && !rom_valid) stale <= 1'b1;
            end else if (!issued) begin
              if (req_ok) begin
                issued  <= 1'b1;
                rom_req <= 1'b1;
                pending <= 1'b1;
                stale   <= 1'b0;
              end
            end else if (rsp_ok) begin
              if (ptr == PTR_LAST) last <= 1'b1;
              else                 ptr  <= ptr + 1'b1;
              if (rom_dur == DUR_W'(DUR_END)) begin
                state <= ST_SONG_END;
              end else begin
                note       <= rom_note;
                remaining  <= rom_dur;
                note_valid <= 1'b1;
                new_note   <= 1'b1;
                state      <= ST_PLAY;
              end
            end
          end
          ST_PLAY: begin
            if (play_pause) begin
              state <= ST_PAUSED;
            end else if (beat) begin
              remaining <= remaining - 1'b1;
              if (remaining == DUR_W'(1)) begin
                if (last) begin
                  state <= ST_SONG_END;
                end else begin
                  state  <= ST_FETCH;
                  issued <= 1'b0;
                end
              end
            end
          end
          ST_SONG_END: begin
            ptr        <= '0;
            last       <= 1'b0;
            note       <= NOTE_W'(NOTE_REST);
            note_valid <= 1'b0;
            if (loop) begin
              state  <= ST_FETCH;
              issued <= 1'b0;
            end else begin
              song  <= song_inc(song);
              state <= ST_PAUSED;
            end
          end
          default: state <= ST_PAUSED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: 3 songs, 4-entry songs, short beats.
module tb_music_sequencer;

  localparam int NUM_SONGS = 3;
  localparam int PTR_W     = 2;
  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;
  localparam int SONG_W    = 2;
  localparam int EV_REQ    = 0;
  localparam int EV_NOTE   = 1;
  localparam int EV_DONE   = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play_pause = 1'b0;
  logic next = 1'b0;
  logic prev = 1'b0;
  logic loop = 1'b0;
  logic new_frame = 1'b0;
  logic rom_req;
  logic [SONG_W+PTR_W-1:0] rom_addr;
  logic rom_valid;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic play;
  logic [SONG_W-1:0] song;
  logic [NOTE_W-1:0] note;
  logic note_valid;
  logic new_note;
  logic sample_tick;
  logic beat;
  logic song_done;

  music_sequencer #(
    .NUM_SONGS(NUM_SONGS), .PTR_W(PTR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
    .BEAT_DIV(1000), .SIM(1)
  ) dut (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
    .loop(loop), .new_frame(new_frame), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_valid(rom_valid), .rom_data(rom_data), .play(play), .song(song),
    .note(note), .note_valid(note_valid), .new_note(new_note),
    .sample_tick(sample_tick), .beat(beat), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Frame strobe: one rising edge every 4 clocks, placed off the clock edge.
  initial forever begin
    repeat (2) @(posedge clk);
    #3 new_frame = ~new_frame;
  end

  // ROM model with a variable response latency.
  logic [11:0] rom_mem [16];
  logic [7:0]  pipe_v = '0;
  logic [3:0]  pipe_a [8];
  int          rom_lat = 1;

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    pipe_v[0] <= rom_req;
    pipe_a[0] <= rom_addr;
  end

  assign rom_valid = pipe_v[rom_lat-1];
  assign rom_data  = rom_mem[pipe_a[rom_lat-1]];

  // Scoreboard of expected output events, in order.
  typedef struct {int kind; int val; int beats;} ev_t;
  ev_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_req = 0, n_note = 0, n_done = 0, n_beat = 0, n_tick = 0;
  int beats_since = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic exp_ev(input int k, input int v, input int b);
    ev_t e;
    e.kind = k;
    e.val = v;
    e.beats = b;
    exp_q.push_back(e);
  endtask

  task automatic see_ev(input int k, input int v, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", k), v, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", k, e.kind);
    case (k)
      EV_REQ:  chk("req_addr", v, e.val);
      EV_NOTE: chk("note_value", v, e.val);
      default: chk("done_song", v, e.val);
    endcase
    if (e.beats >= 0) chk("beats_per_note", b, e.beats);
  endtask

  // Output monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      beats_since = 0;
    end else begin
      if (sample_tick) n_tick++;
      if (play && beat) begin
        beats_since++;
        n_beat++;
      end
      if (rom_req) begin
        n_req++;
        see_ev(EV_REQ, int'(rom_addr), -1);
      end
      if (new_note) begin
        n_note++;
        see_ev(EV_NOTE, int'(note), beats_since);
        beats_since = 0;
      end
      if (song_done) begin
        n_done++;
        see_ev(EV_DONE, int'(song), beats_since);
      end
    end
  end

  function automatic int get_cnt(input int which);
    case (which)
      0: return n_req;
      1: return n_note;
      2: return n_done;
      3: return n_beat;
      default: return n_tick;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int amount, input int max_cyc);
    int start;
    int c;
    start = get_cnt(which);
    c = 0;
    while ((get_cnt(which) - start) < amount && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    if ((get_cnt(which) - start) < amount)
      chk({"timeout_", tag}, get_cnt(which) - start, amount);
  endtask

  task automatic press(input logic pp, input logic nx, input logic pv);
    @(posedge clk);
    #1;
    play_pause = pp;
    next = nx;
    prev = pv;
    @(posedge clk);
    #1;
    play_pause = 1'b0;
    next = 1'b0;
    prev = 1'b0;
  endtask

  function automatic logic [11:0] ent(input int n, input int d);
    return {6'(n), 6'(d)};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
    rom_mem[0]  = ent(5, 2);  rom_mem[1]  = ent(9, 1);  rom_mem[2]  = ent(7, 0);
    rom_mem[4]  = ent(3, 1);  rom_mem[5]  = ent(0, 1);  rom_mem[6]  = ent(12, 1);
    rom_mem[7]  = ent(20, 1);
    rom_mem[8]  = ent(33, 3); rom_mem[9]  = ent(40, 1); rom_mem[10] = ent(0, 0);

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_play", play, 0);
    chk("rst_song", song, 0);
    chk("rst_note", note, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pulses", {rom_req, new_note, song_done, beat, sample_tick, note_valid}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a note
    exp_ev(EV_REQ, 0, -1);
    exp_ev(EV_NOTE, 5, -1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("first_note", 1, 1, 200);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_play", play, 0);
    chk("midrst_song", song, 0);
    chk("midrst_note", {note_valid, note}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Song 0 end to end
    exp_ev(EV_REQ, 0, -1);  exp_ev(EV_NOTE, 5, -1);
    exp_ev(EV_REQ, 1, -1);  exp_ev(EV_NOTE, 9, 2);
    exp_ev(EV_REQ, 2, -1);  exp_ev(EV_DONE, 0, 1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("song0_done", 2, 1, 3000);
    @(negedge clk);
    chk("song0_next_song", song, 1);
    chk("song0_play_off", play, 0);
    chk("song0_silent", {note_valid, note}, 0);

    // Loop mode replays song 0
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("prev_to_0", song, 0);
    loop = 1'b1;
    exp_ev(EV_REQ, 0, -1);  exp_ev(EV_NOTE, 5, -1);
    exp_ev(EV_REQ, 1, -1);  exp_ev(EV_NOTE, 9, 2);
    exp_ev(EV_REQ, 2, -1);  exp_ev(EV_DONE, 0, 1);
    exp_ev(EV_REQ, 0, -1);  exp_ev(EV_NOTE, 5, -1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("loop_notes", 1, 3, 4000);
    @(negedge clk);
    chk("loop_play", play, 1);
    chk("loop_song", song, 0);
    chk("loop_note", note, 5);
    loop = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_song", song, 1);
    chk("abort_play", play, 0);
    chk("abort_silent", {note_valid, note}, 0);

    // Song index wrap and next/prev priority
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("prev_1_to_0", song, 0);
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("prev_wrap", song, 2);
    chk("prev_wrap_state", {play, note_valid}, 0);
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("prev_2_to_1", song, 1);
    press(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("next_beats_prev", song, 2);

    // Abort while a request is outstanding; stale reply must be dropped
    rom_lat = 6;
    exp_ev(EV_REQ, 8, -1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("stale_req", 0, 1, 50);
    press(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stale_abort_play", play, 0);
    chk("stale_abort_song", song, 0);
    exp_ev(EV_REQ, 0, -1);
    exp_ev(EV_NOTE, 5, -1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("fresh_note", 1, 1, 100);
    @(negedge clk);
    chk("fresh_note_val", note, 5);
    press(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fresh_abort_song", song, 1);

    // Full 4-entry song: no fetch past the last pointer
    rom_lat = 2;
    exp_ev(EV_REQ, 4, -1);  exp_ev(EV_NOTE, 3, -1);
    exp_ev(EV_REQ, 5, -1);  exp_ev(EV_NOTE, 0, 1);
    exp_ev(EV_REQ, 6, -1);  exp_ev(EV_NOTE, 12, 1);
    exp_ev(EV_REQ, 7, -1);  exp_ev(EV_NOTE, 20, 1);
    exp_ev(EV_DONE, 1, 1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("song1_done", 2, 1, 6000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("song1_next_song", song, 2);
    chk("song1_play_off", play, 0);

    // Pause mid-note keeps remaining beats
    exp_ev(EV_REQ, 8, -1);
    exp_ev(EV_NOTE, 33, -1);
    press(1'b1, 1'b0, 1'b0);
    wait_cnt("note33", 1, 1, 200);
    wait_cnt("first_beat", 3, 1, 400);
    repeat (20) @(posedge clk);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("paused_play", play, 0);
    chk("paused_held", {note_valid, note}, {1'b1, 6'd33});
    exp_ev(EV_REQ, 9, -1);  exp_ev(EV_NOTE, 40, 3);
    exp_ev(EV_REQ, 10, -1); exp_ev(EV_DONE, 2, 1);
    wait_cnt("pause_hold", 4, 500, 3000);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("resume_play", play, 1);
    chk("resume_note", note, 33);
    wait_cnt("song2_done", 2, 1, 3000);
    @(negedge clk);
    chk("song2_wrap", song, 0);
    chk("song2_play_off", play, 0);

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
